// File: rtl/debug_host.sv
// rtl/debug_host.sv - UART debug protocol host: loads a program, starts it, captures a memory dump
//
// Build option: DEBUG_HOST_TIMEOUT_EN enables the RECV idle timeout that drives o_error.
//
// Ports:
//   i_clock, i_reset        system clock, asynchronous active-low reset
//   i_start                 start-sequence pulse (ignored while o_busy)
//   i_prog_size, i_mode     program length and run mode, latched on an accepted i_start
//   o_prog_addr/i_prog_data program ROM read port (data valid one cycle after address)
//   o_tx_data/o_tx_start    byte and one-cycle request to the UART transmitter
//   i_tx_done               transmitter finished the current byte
//   i_rx_data/i_rx_done     received byte and its one-cycle valid strobe
//   o_cap_we/addr/data      capture RAM write port for the memory dump
//   o_busy, o_done, o_error sequence status
module debug_host #(
  parameter int NB_DATA      = 8,
  parameter int NB_SIZE      = 16,
  parameter int NB_PROG_ADDR = 8,
  parameter int NB_ADDR_DM   = 7,
  parameter int DM_DEPTH     = 128,
  parameter int RUN_WAIT     = 1024,
  parameter int TIMEOUT      = 65535
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [NB_SIZE-1:0]      i_prog_size,
  input  logic                    i_mode,
  output logic [NB_PROG_ADDR-1:0] o_prog_addr,
  input  logic [NB_DATA-1:0]      i_prog_data,
  output logic [NB_DATA-1:0]      o_tx_data,
  output logic                    o_tx_start,
  input  logic                    i_tx_done,
  input  logic [NB_DATA-1:0]      i_rx_data,
  input  logic                    i_rx_done,
  output logic                    o_cap_we,
  output logic [NB_ADDR_DM-1:0]   o_cap_addr,
  output logic [NB_DATA-1:0]      o_cap_data,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_error
);

  localparam int WAIT_W = $clog2(RUN_WAIT + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD_LOAD,
    S_SIZE_LO,
    S_SIZE_HI,
    S_FETCH,
    S_SEND_PROG,
    S_CMD_MODE,
    S_RUN_WAIT,
    S_CMD_DUMP,
    S_RECV,
    S_DONE
  } state_t;

  state_t                  state;
  state_t                  send_next;
  logic [NB_DATA-1:0]      send_byte;
  logic                    tx_wait;   // send state is in its wait-for-done phase
  logic                    rom_wait;  // SEND_PROG waiting for the ROM read latency
  logic [NB_SIZE-1:0]      size_q;
  logic                    mode_q;
  logic [NB_SIZE-1:0]      idx;
  logic [WAIT_W-1:0]       wait_cnt;
  logic [NB_ADDR_DM-1:0]   rx_cnt;
  logic                    rx_pend;   // received byte registered, written next cycle
  logic [NB_DATA-1:0]      rx_byte;

`ifdef DEBUG_HOST_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0]         to_cnt;
`else
  logic                    unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  // Byte and successor for the fixed-content send states
  always_comb begin
    send_byte = '0;
    send_next = S_IDLE;
    case (state)
      S_CMD_LOAD: begin send_byte = NB_DATA'(8'h01);               send_next = S_SIZE_LO;  end
      S_SIZE_LO:  begin send_byte = NB_DATA'(size_q);              send_next = S_SIZE_HI;  end
      S_SIZE_HI:  begin send_byte = NB_DATA'(size_q >> NB_DATA);   send_next = S_FETCH;    end
      S_CMD_MODE: begin
        send_byte = mode_q ? NB_DATA'(8'h05) : NB_DATA'(8'h04);
        send_next = S_RUN_WAIT;
      end
      S_CMD_DUMP: begin send_byte = NB_DATA'(8'h08);               send_next = S_RECV;     end
      default:    begin send_byte = '0;                            send_next = S_IDLE;     end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state       <= S_IDLE;
      tx_wait     <= 1'b0;
      rom_wait    <= 1'b0;
      size_q      <= '0;
      mode_q      <= 1'b0;
      idx         <= '0;
      wait_cnt    <= '0;
      rx_cnt      <= '0;
      rx_pend     <= 1'b0;
      rx_byte     <= '0;
      o_prog_addr <= '0;
      o_tx_data   <= '0;
      o_tx_start  <= 1'b0;
      o_cap_we    <= 1'b0;
      o_cap_addr  <= '0;
      o_cap_data  <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
`ifdef DEBUG_HOST_TIMEOUT_EN
      to_cnt      <= '0;
`endif
    end else begin
      o_tx_start <= 1'b0;
      o_cap_we   <= 1'b0;
      // Bytes arriving outside RECV never enter the capture pipeline
      rx_pend    <= i_rx_done && (state == S_RECV);
      rx_byte    <= i_rx_data;

      case (state)
        S_IDLE: begin
          if (i_start) begin
            size_q  <= i_prog_size;
            mode_q  <= i_mode;
            o_done  <= 1'b0;
            o_error <= 1'b0;
            o_busy  <= 1'b1;
            idx     <= '0;
            tx_wait <= 1'b0;
            state   <= S_CMD_LOAD;
          end
        end

        S_CMD_LOAD, S_SIZE_LO, S_SIZE_HI, S_CMD_MODE, S_CMD_DUMP: begin
          if (!tx_wait) begin
            o_tx_start <= 1'b1;
            o_tx_data  <= send_byte;
            tx_wait    <= 1'b1;
          end else if (i_tx_done && !o_tx_start) begin
            // A done coincident with our own start strobe belongs to an older byte
            tx_wait  <= 1'b0;
            wait_cnt <= '0;
            rx_cnt   <= '0;
`ifdef DEBUG_HOST_TIMEOUT_EN
            to_cnt   <= '0;
`endif
            state    <= send_next;
          end
        end

        S_FETCH: begin
          // Address wraps modulo the ROM size; the count compares at full width
          o_prog_addr <= NB_PROG_ADDR'(idx);
          if (idx == size_q) begin
            state <= S_CMD_MODE;
          end else begin
            rom_wait <= 1'b1;
            state    <= S_SEND_PROG;
          end
        end

        S_SEND_PROG: begin
          if (rom_wait) begin
            rom_wait <= 1'b0;
          end else if (!tx_wait) begin
            o_tx_start <= 1'b1;
            o_tx_data  <= i_prog_data;
            tx_wait    <= 1'b1;
          end else if (i_tx_done && !o_tx_start) begin
            tx_wait <= 1'b0;
            idx     <= idx + NB_SIZE'(1);
            state   <= S_FETCH;
          end
        end

        S_RUN_WAIT: begin
          // Two cycles of the interval are spent entering and leaving this state
          if (wait_cnt == WAIT_W'(RUN_WAIT - 2)) begin
            state <= S_CMD_DUMP;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        S_RECV: begin
          if (rx_pend) begin
            o_cap_we   <= 1'b1;
            o_cap_addr <= rx_cnt;
            o_cap_data <= rx_byte;
            if (rx_cnt == NB_ADDR_DM'(DM_DEPTH - 1)) begin
              state <= S_DONE;
            end else begin
              rx_cnt <= rx_cnt + NB_ADDR_DM'(1);
            end
          end
`ifdef DEBUG_HOST_TIMEOUT_EN
          if (i_rx_done) begin
            to_cnt <= '0;
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            o_error <= 1'b1;
            o_busy  <= 1'b0;
            state   <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
`endif
        end

        S_DONE: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_host.sv
// tb/tb_debug_host.sv - self-checking bench for debug_host
`timescale 1ns/1ps
module tb_debug_host;

  localparam int RUN_WAIT = 1024;
  localparam int TIMEOUT  = 100;
  localparam int DLY      = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [15:0] i_prog_size = '0;
  logic        i_mode = 1'b0;
  logic [7:0]  o_prog_addr;
  logic [7:0]  rom_q = '0;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        i_tx_done = 1'b0;
  logic [7:0]  i_rx_data = '0;
  logic        i_rx_done = 1'b0;
  logic        o_cap_we;
  logic [6:0]  o_cap_addr;
  logic [7:0]  o_cap_data;
  logic        o_busy, o_done, o_error;

  debug_host #(.RUN_WAIT(RUN_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_start(i_start), .i_prog_size(i_prog_size),
    .i_mode(i_mode), .o_prog_addr(o_prog_addr), .i_prog_data(rom_q),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
    .i_rx_data(i_rx_data), .i_rx_done(i_rx_done), .o_cap_we(o_cap_we),
    .o_cap_addr(o_cap_addr), .o_cap_data(o_cap_data), .o_busy(o_busy),
    .o_done(o_done), .o_error(o_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] rom [256];
  always @(posedge clk) rom_q <= rom[o_prog_addr];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // UART TX model: logs each requested byte, answers with i_tx_done DLY cycles later
  logic [7:0] tx_log [16];
  int start_edge [16];
  int done_edge [16];
  int ntx = 0, ndone = 0, resp_k = 0;
  bit early_mode = 0, poke_start = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (o_tx_start) begin
        resp_k = ntx;
        if (resp_k < 16) begin
          tx_log[resp_k] = o_tx_data;
          start_edge[resp_k] = cyc;
        end
        ntx++;
        if (poke_start && resp_k == 1) begin
          i_start = 1'b1; i_prog_size = 16'h0005; i_mode = ~i_mode;
        end
        if (early_mode) i_tx_done = 1'b1;
        @(negedge clk);
        if (poke_start && resp_k == 1) i_start = 1'b0;
        i_tx_done = 1'b0;
        repeat (DLY - 1) @(negedge clk);
        if (rst_n && resp_k < 16) chk("tx_data_hold", o_tx_data, tx_log[resp_k]);
        i_tx_done = 1'b1;
        if (resp_k < 16) done_edge[resp_k] = cyc + 1;
        @(negedge clk);
        i_tx_done = 1'b0;
        ndone++;
      end
    end
  end

  // Capture RAM model
  logic [7:0] cap_mem [128];
  int cap_wr = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (o_cap_we) begin
        cap_mem[o_cap_addr] = o_cap_data;
        cap_wr++;
      end
    end
  end

  typedef struct {
    logic [15:0]     size;
    logic            mode;
    bit              early;
    bit              poke;
    logic [7:0]      seed;
    int              n_tx;
    logic [9:0][7:0] exp;
  } scn_t;

  scn_t tbl [4];
  int   rlast = 0;

  task automatic start_seq(input logic [15:0] size, input logic mode, input string tag);
    @(negedge clk);
    i_prog_size = size; i_mode = mode; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk({tag, "_tx_start_edgeN"}, o_tx_start, 0);
    @(negedge clk);
    chk({tag, "_busy"}, o_busy, 1);
    chk({tag, "_tx_start"}, o_tx_start, 1);
    chk({tag, "_tx_data"}, o_tx_data, 8'h01);
    chk({tag, "_flags_clr"}, {o_done, o_error}, 0);
  endtask

  task automatic wait_tx(input int n, input string tag);
    for (int w = 0; w < 5000 && ndone < n; w++) @(negedge clk);
    chk({tag, "_tx_done_count"}, ndone, n);
  endtask

  task automatic rx_byte(input logic [7:0] d);
    @(negedge clk);
    i_rx_done = 1'b1; i_rx_data = d; rlast = cyc + 1;
    @(negedge clk);
    i_rx_done = 1'b0;
  endtask

  task automatic run_scn(input int s);
    string tag;
    int bad;
    int gexp;
    tag = $sformatf("s%0d", s);
    ntx = 0; ndone = 0; cap_wr = 0;
    for (int i = 0; i < 128; i++) cap_mem[i] = 8'h00;
    early_mode = tbl[s].early; poke_start = tbl[s].poke;
    start_seq(tbl[s].size, tbl[s].mode, tag);
    @(negedge clk);
    i_rx_done = 1'b1; i_rx_data = 8'hEE;
    @(negedge clk);
    i_rx_done = 1'b0;
    wait_tx(tbl[s].n_tx, tag);
    repeat (2) @(negedge clk);
    chk({tag, "_stray_rx"}, cap_wr, 0);
    chk({tag, "_tx_count"}, ntx, tbl[s].n_tx);
    for (int i = 0; i < tbl[s].n_tx; i++)
      chk($sformatf("%s_tx_byte%0d", tag, i), tx_log[i], tbl[s].exp[i]);
    for (int i = 1; i < tbl[s].n_tx; i++) begin
      if (i == tbl[s].n_tx - 1)       gexp = RUN_WAIT;
      else if (i == tbl[s].n_tx - 2)  gexp = -1;
      else if (i >= 3)                gexp = 3;
      else                            gexp = 1;
      if (gexp >= 0)
        chk($sformatf("%s_tx_gap%0d", tag, i), start_edge[i] - done_edge[i-1], gexp);
    end
    rx_byte(8'h00 ^ tbl[s].seed);
    chk({tag, "_cap_we_edgeR"}, o_cap_we, 0);
    @(negedge clk);
    chk({tag, "_cap_we_edgeR1"}, {o_cap_we, o_cap_addr}, {1'b1, 7'd0});
    for (int n = 1; n < 128; n++) rx_byte(8'(n) ^ tbl[s].seed);
    for (int w = 0; w < 10 && !o_done; w++) @(negedge clk);
    chk({tag, "_done"}, o_done, 1);
    chk({tag, "_busy_end"}, o_busy, 0);
    chk({tag, "_error_end"}, o_error, 0);
    chk({tag, "_cap_writes"}, cap_wr, 128);
    bad = 0;
    for (int n = 0; n < 128; n++) if (cap_mem[n] !== (8'(n) ^ tbl[s].seed)) bad++;
    chk({tag, "_cap_bad_entries"}, bad, 0);
    repeat (5) @(negedge clk);
    chk({tag, "_done_held"}, o_done, 1);
  endtask

  int snap_cap, snap_tx, lat;

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'h11;
    rom[0] = 8'hAA; rom[1] = 8'hBB; rom[2] = 8'hCC;

    tbl[0] = '{size: 16'd3, mode: 1'b0, early: 1'b0, poke: 1'b0, seed: 8'h00, n_tx: 8,
               exp: {8'h00, 8'h00, 8'h08, 8'h04, 8'hCC, 8'hBB, 8'hAA, 8'h00, 8'h03, 8'h01}};
    tbl[1] = '{size: 16'd0, mode: 1'b1, early: 1'b1, poke: 1'b0, seed: 8'hA5, n_tx: 5,
               exp: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h05, 8'h00, 8'h00, 8'h01}};
    tbl[2] = '{size: 16'd2, mode: 1'b0, early: 1'b0, poke: 1'b1, seed: 8'h3C, n_tx: 7,
               exp: {8'h00, 8'h00, 8'h00, 8'h08, 8'h04, 8'hBB, 8'hAA, 8'h00, 8'h02, 8'h01}};
    tbl[3] = '{size: 16'd1, mode: 1'b1, early: 1'b1, poke: 1'b0, seed: 8'hFF, n_tx: 6,
               exp: {8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h05, 8'hAA, 8'h00, 8'h01, 8'h01}};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {o_prog_addr, o_tx_data, o_tx_start, o_cap_we, o_cap_addr,
                          o_cap_data, o_busy, o_done, o_error}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", {o_busy, o_tx_start, o_cap_we}, 0);

    for (int s = 0; s < 4; s++) run_scn(s);

    // Reset in the middle of a dump, then restart
    ntx = 0; ndone = 0; cap_wr = 0; early_mode = 0; poke_start = 0;
    start_seq(16'd3, 1'b0, "rst");
    wait_tx(8, "rst");
    repeat (2) @(negedge clk);
    for (int n = 0; n < 50; n++) rx_byte(8'(n));
    @(negedge clk);
    chk("rst_cap_before", cap_wr, 50);
    rst_n = 1'b0;
    #1;
    chk("rst_outputs_async", {o_prog_addr, o_tx_data, o_tx_start, o_cap_we, o_cap_addr,
                              o_cap_data, o_busy, o_done, o_error}, 0);
    snap_cap = cap_wr; snap_tx = ntx;
    rx_byte(8'h55);
    rx_byte(8'h56);
    rst_n = 1'b1;
    rx_byte(8'h57);
    repeat (20) @(negedge clk);
    chk("rst_no_cap", cap_wr, snap_cap);
    chk("rst_no_tx", ntx, snap_tx);
    chk("rst_idle", o_busy, 0);

    ntx = 0; ndone = 0; cap_wr = 0;
    start_seq(16'd0, 1'b0, "restart");
    wait_tx(5, "restart");
    chk("restart_mode_byte", tx_log[3], 8'h04);
    chk("restart_dump_byte", tx_log[4], 8'h08);
    repeat (2) @(negedge clk);
    for (int n = 0; n < 5; n++) rx_byte(8'(n) + 8'h40);

`ifdef DEBUG_HOST_TIMEOUT_EN
    lat = -1;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (o_error) begin
        lat = cyc - rlast;
        break;
      end
    end
    chk("timeout_latency_in_range", (lat >= TIMEOUT && lat <= TIMEOUT + 1), 1);
    chk("timeout_flags", {o_error, o_done, o_busy}, 3'b100);
    chk("timeout_cap_writes", cap_wr, 5);
    ntx = 0; ndone = 0;
    start_seq(16'd0, 1'b1, "after_timeout");
`else
    repeat (300) @(negedge clk);
    chk("no_timeout_error", o_error, 0);
    chk("no_timeout_busy", o_busy, 1);
    chk("no_timeout_cap_writes", cap_wr, 5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule
